// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word array shared by the core and a host
// load port, byte-lane writes, fixed-latency read pipeline tagged by port.
module dmem_responder #(
   parameter int unsigned DEPTH         = 1024,
   parameter int unsigned DM_ADDR_WIDTH = 10,
   parameter int unsigned RD_LAT        = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               dm_we_i,
   input  logic                     dm_re_i,
   input  logic [DM_ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [31:0]              dm_writedata_i,
   output logic [31:0]              dm_readdata_o,
   output logic                     dm_rvalid_o,
   output logic                     dm_err_o,
   input  logic                     host_sel_i,
   input  logic                     host_we_i,
   input  logic [DM_ADDR_WIDTH-1:0] host_addr_i,
   input  logic [31:0]              host_wdata_i,
   output logic [31:0]              host_rdata_o,
   output logic [15:0]              drop_cnt_o
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LAST  = RD_LAT - 1;

   logic [31:0] mem [DEPTH];

   logic [DM_ADDR_WIDTH-1:0] port_addr;
   logic [IDX_W-1:0]         port_idx;
   logic                     port_oor;
   logic                     core_req;
   logic                     rd_fire;
   logic [3:0]               wr_be;
   logic [31:0]              wr_data;
   logic [31:0]              ram_word;

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [RD_LAT-1:0] hst_q, hst_d;
   logic [31:0]       dat_q [RD_LAT];
   logic [31:0]       dat_d [RD_LAT];
   logic [RD_LAT-1:0] in_v, in_h;
   logic [31:0]       in_d [RD_LAT];
   logic [31:0]       host_rdata_q, host_rdata_d;
   logic              err_q, err_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   always_comb begin
      core_req  = dm_re_i | (|dm_we_i);
      port_addr = host_sel_i ? host_addr_i : dm_addr_i;
      port_idx  = port_addr[IDX_W-1:0];
      port_oor  = 32'(port_addr) >= 32'(DEPTH);
      wr_data   = host_sel_i ? host_wdata_i : dm_writedata_i;
      wr_be     = host_sel_i ? {4{host_we_i}} : dm_we_i;
      if (rst || port_oor) begin
         wr_be = '0;
      end
      rd_fire   = host_sel_i ? ~host_we_i : dm_re_i;
      ram_word  = port_oor ? '0 : mem[port_idx];
   end

   // Unreset array; read-first falls out of capturing the old word on the write edge.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < 4; b++) begin
         if (wr_be[b]) begin
            mem[port_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Each stage carries a port tag so reads in flight finish on the port that issued them.
   always_comb begin
      in_v[0] = rd_fire;
      in_h[0] = host_sel_i;
      in_d[0] = ram_word;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
         in_v[k] = vld_q[k-1];
         in_h[k] = hst_q[k-1];
         in_d[k] = dat_q[k-1];
      end
      vld_d = in_v;
      hst_d = in_h;
      dat_d = dat_q;
      for (int unsigned k = 0; k < LAST; k++) begin
         dat_d[k] = in_d[k];
      end
      if (in_v[LAST] && !in_h[LAST]) begin
         dat_d[LAST] = in_d[LAST];
      end
      host_rdata_d = (in_v[LAST] && in_h[LAST]) ? in_d[LAST] : host_rdata_q;
      err_d        = ~host_sel_i & core_req & port_oor;
      drop_cnt_d   = drop_cnt_q;
      if (host_sel_i && core_req && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q        <= '0;
         hst_q        <= '0;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            dat_q[k] <= '0;
         end
         host_rdata_q <= '0;
         err_q        <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         vld_q        <= vld_d;
         hst_q        <= hst_d;
         dat_q        <= dat_d;
         host_rdata_q <= host_rdata_d;
         err_q        <= err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign dm_readdata_o = dat_q[LAST];
   assign dm_rvalid_o   = vld_q[LAST] & ~hst_q[LAST];
   assign dm_err_o      = err_q;
   assign host_rdata_o  = host_rdata_q;
   assign drop_cnt_o    = drop_cnt_q;

endmodule
